csr_access_seq: RTL and testbench

- Multi-cycle sequencer for Zicsr instructions in the pipelined Otter.
- Accepts a decoded CSR instruction from the decode stage and extracts the 12-bit CSR address (I-type immediate field, IR[31:20]) and the 5-bit zimm (IR[19:15]).
- Performs a read-modify-write on the CSR file and returns the old value for rd writeback.
- Stalls the pipeline front end for the duration of the access.

---
 rtl/csr_pkg.sv | 22 ++
 rtl/csr_wdata_alu.sv | 21 ++
 rtl/csr_access_seq.sv | 120 ++++++++++++
 tb/tb_csr_access_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared types and constants for the Zicsr access sequencer.
package csr_pkg;

  typedef enum logic [2:0] {
    CSRRW  = 3'b001,
    CSRRS  = 3'b010,
    CSRRC  = 3'b011,
    CSRRWI = 3'b101,
    CSRRSI = 3'b110,
    CSRRCI = 3'b111
  } csr_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } csr_state_e;

  // CSR address prefix reserved for read-only registers
  localparam logic [1:0] RO_PREFIX = 2'b11;

endpackage

// File: rtl/csr_wdata_alu.sv
// Computes the CSR write value from funct3[1:0], the old CSR value and the operand.
module csr_wdata_alu #(
  parameter int XLEN = 32
) (
  input  logic [1:0]      kind,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] new_val
);

  always_comb begin
    new_val = old_val;
    case (kind)
      2'b01:   new_val = operand;
      2'b10:   new_val = old_val | operand;
      2'b11:   new_val = old_val & ~operand;
      default: new_val = old_val;
    endcase
  end

endmodule

// File: rtl/csr_access_seq.sv
// Three-cycle read-modify-write sequencer for Zicsr instructions.
// state | meaning
// IDLE  | ready; accepts and latches a decoded CSR instruction
// READ  | CSR read strobe (skipped for CSRRW/CSRRWI with rd==x0)
// WRITE | CSR write, GPR writeback or illegal pulse; retires the instruction
module csr_access_seq
  import csr_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit RO_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [24:0]     ir,
  input  logic [XLEN-1:0] rs1_data,
  output logic [11:0]     csr_addr,
  output logic            csr_re,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            csr_we,
  output logic [XLEN-1:0] csr_wdata,
  output logic            rd_we,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            stall,
  output logic            illegal
);

  csr_state_e      state_q, state_d;
  logic [11:0]     addr_q;
  logic [4:0]      rd_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] operand_q;
  logic            field_nz_q;

  logic            accept;
  logic            skip_read;
  logic            write_intent;
  logic            illegal_op;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;

  assign accept = (state_q == IDLE) && req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      operand_q  <= '0;
      field_nz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= ir[24:13];
        rd_q       <= ir[4:0];
        funct3_q   <= ir[7:5];
        operand_q  <= ir[7] ? {{(XLEN-5){1'b0}}, ir[12:8]} : rs1_data;
        field_nz_q <= (ir[12:8] != 5'd0);
      end
    end
  end

  // Plain writes with rd==x0 must not touch the CSR read side effects
  assign skip_read    = ((funct3_q == CSRRW) || (funct3_q == CSRRWI)) && (rd_q == 5'd0);
  assign write_intent = (funct3_q[1:0] == 2'b01) || field_nz_q;
  assign illegal_op   = (funct3_q[1:0] == 2'b00) ||
                        (RO_CHECK && (addr_q[11:10] == RO_PREFIX) && write_intent);
  assign old_val      = skip_read ? '0 : csr_rdata;
  assign csr_addr     = addr_q;

  csr_wdata_alu #(.XLEN(XLEN)) u_alu (
    .kind    (funct3_q[1:0]),
    .old_val (old_val),
    .operand (operand_q),
    .new_val (new_val)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    stall     = 1'b0;
    csr_re    = 1'b0;
    csr_we    = 1'b0;
    csr_wdata = '0;
    rd_we     = 1'b0;
    rd_addr   = '0;
    rd_data   = '0;
    illegal   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) state_d = READ;
      end
      READ: begin
        stall   = 1'b1;
        csr_re  = !skip_read;
        state_d = WRITE;
      end
      WRITE: begin
        illegal = illegal_op;
        if (write_intent && !illegal_op) begin
          csr_we    = 1'b1;
          csr_wdata = new_val;
        end
        if ((rd_q != 5'd0) && !illegal_op) begin
          rd_we   = 1'b1;
          rd_addr = rd_q;
          rd_data = old_val;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_access_seq.sv
// Self-checking bench: directed plan cases plus random CSR instructions against a reference CSR model.
module tb_csr_access_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [24:0] ir;
  logic [31:0] rs1_data;
  logic [11:0] csr_addr;
  logic        csr_re;
  logic [31:0] csr_rdata;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        stall;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] csr_mem [4096];
  logic [31:0] ref_mem [4096];

  csr_access_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .ir        (ir),
    .rs1_data  (rs1_data),
    .csr_addr  (csr_addr),
    .csr_re    (csr_re),
    .csr_rdata (csr_rdata),
    .csr_we    (csr_we),
    .csr_wdata (csr_wdata),
    .rd_we     (rd_we),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .stall     (stall),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // CSR file model: read data appears the cycle after the strobe
  always @(posedge clk) begin
    csr_rdata <= csr_re ? csr_mem[csr_addr] : $urandom;
    if (csr_we) csr_mem[csr_addr] <= csr_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] v);
    csr_mem[a] = v;
    ref_mem[a] = v;
  endtask

  // One instruction from accept to retire; req_valid stays high with junk
  // in cycles 1-2 so the next call accepts back-to-back at cycle 3.
  task automatic run_csr(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] field,
                         input logic [4:0] rd, input logic [31:0] rs1, input bit hold_valid);
    logic [31:0] operand, old, nv;
    bit writes, ill, reads;
    operand = f3[2] ? {27'd0, field} : rs1;
    writes  = (f3[1:0] == 2'b01) || (field != 5'd0);
    ill     = (f3[1:0] == 2'b00) || ((a[11:10] == 2'b11) && writes);
    reads   = !((f3[1:0] == 2'b01) && (rd == 5'd0));
    old     = reads ? ref_mem[a] : 32'd0;
    case (f3[1:0])
      2'b01:   nv = operand;
      2'b10:   nv = old | operand;
      2'b11:   nv = old & ~operand;
      default: nv = old;
    endcase

    @(negedge clk);
    req_valid = 1'b1;
    ir        = {a, field, f3, rd};
    rs1_data  = rs1;
    #1;
    check("c0_ready", {31'd0, req_ready}, 32'd1);
    check("c0_stall", {31'd0, stall}, 32'd1);

    @(negedge clk);
    req_valid = hold_valid;
    ir        = $urandom;
    rs1_data  = $urandom;
    #1;
    check("c1_ready", {31'd0, req_ready}, 32'd0);
    check("c1_stall", {31'd0, stall}, 32'd1);
    check("c1_re", {31'd0, csr_re}, {31'd0, reads});
    check("c1_addr", {20'd0, csr_addr}, {20'd0, a});
    check("c1_we", {31'd0, csr_we}, 32'd0);

    @(negedge clk);
    ir       = $urandom;
    rs1_data = $urandom;
    #1;
    check("c2_ready", {31'd0, req_ready}, 32'd0);
    check("c2_stall", {31'd0, stall}, 32'd0);
    check("c2_re", {31'd0, csr_re}, 32'd0);
    check("c2_addr", {20'd0, csr_addr}, {20'd0, a});
    check("c2_illegal", {31'd0, illegal}, {31'd0, ill});
    check("c2_we", {31'd0, csr_we}, {31'd0, writes && !ill});
    if (writes && !ill) check("c2_wdata", csr_wdata, nv);
    check("c2_rd_we", {31'd0, rd_we}, {31'd0, (rd != 5'd0) && !ill});
    if ((rd != 5'd0) && !ill) begin
      check("c2_rd_addr", {27'd0, rd_addr}, {27'd0, rd});
      check("c2_rd_data", rd_data, old);
    end
    if (writes && !ill) ref_mem[a] = nv;
  endtask

  task automatic end_burst();
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("idle_ready", {31'd0, req_ready}, 32'd1);
    check("idle_stall", {31'd0, stall}, 32'd0);
  endtask

  initial begin
    logic [11:0] ra;
    logic [4:0]  rf, rr;
    for (int i = 0; i < 4096; i++) preload(i[11:0], $urandom);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    ir        = '0;
    rs1_data  = '0;
    #12;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_addr", {20'd0, csr_addr}, 32'd0);
    check("rst_strobes", {28'd0, csr_re, csr_we, rd_we, illegal}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    preload(12'h340, 32'h12345678);
    run_csr(3'b001, 12'h340, 5'd5, 5'd6, 32'hDEADBEEF, 1'b0);
    end_burst();
    preload(12'h300, 32'h00000001);
    run_csr(3'b110, 12'h300, 5'h08, 5'd7, 32'h0, 1'b0);
    run_csr(3'b111, 12'h300, 5'h00, 5'd8, 32'h0, 1'b0);
    run_csr(3'b001, 12'h305, 5'd9, 5'd0, 32'hA5A5_0F0F, 1'b0);
    run_csr(3'b010, 12'h305, 5'd0, 5'd3, 32'hFFFF_FFFF, 1'b0);
    run_csr(3'b001, 12'hC00, 5'd1, 5'd2, 32'h1111_2222, 1'b0);
    run_csr(3'b010, 12'hC00, 5'd0, 5'd2, 32'h0, 1'b0);
    run_csr(3'b000, 12'h341, 5'd4, 5'd4, 32'h5, 1'b0);
    run_csr(3'b011, 12'h342, 5'd4, 5'd4, 32'h0000_00F0, 1'b1);
    run_csr(3'b101, 12'h343, 5'd31, 5'd1, 32'h0, 1'b0);
    end_burst();

    // reset while in READ
    @(negedge clk);
    req_valid = 1'b1;
    ir        = {12'h340, 5'd5, 3'b001, 5'd6};
    rs1_data  = 32'hCAFE_F00D;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("mid_re_before", {31'd0, csr_re}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_re", {31'd0, csr_re}, 32'd0);
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_addr", {20'd0, csr_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("post_rst_we", {30'd0, csr_we, rd_we}, 32'd0);
      check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    end
    check("post_rst_mem", csr_mem[12'h340], ref_mem[12'h340]);

    for (int n = 0; n < 300; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? {2'b11, 10'($urandom)} : 12'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 12'h340;
      rf = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      run_csr(3'($urandom), ra, rf, rr, $urandom, 1'($urandom));
      if ($urandom_range(0, 4) == 0) end_burst();
    end
    end_burst();
    for (int i = 0; i < 4096; i++)
      if (csr_mem[i] !== ref_mem[i]) check("final_mem", csr_mem[i], ref_mem[i]);
    check("final_mem_340", csr_mem[12'h340], ref_mem[12'h340]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
